// File: rtl/ofifo.sv
// Output FIFO behind the MAC array: one FIFO per column, written on that column's
// valid strobe, popped a whole aligned row at a time so column skew is removed.
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_vld,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_cnt = (aw+1)'(depth);

  logic [psum_bw-1:0] mem [col][depth];
  logic [aw-1:0]      wp  [col];
  logic [aw:0]        cnt [col];
  logic [aw-1:0]      rp;

  logic [col-1:0] col_empty;
  logic [col-1:0] col_full;
  logic [col-1:0] wr_acc;
  logic           rd_acc;
  logic           ovf_evt;

  // Status flags look only at registered counts, never at this cycle's strobes.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    col_empty = '0;
    col_full  = '0;
    for (int c = 0; c < col; c++) begin
      col_empty[c] = (cnt[c] == '0);
      col_full[c]  = (cnt[c] == depth_cnt);
    end
  end

  assign o_valid = ~|col_empty;
  assign o_full  = |col_full;
  assign o_ready = ~o_full;
  assign rd_acc  = rd & o_valid;

  // A read in the same edge frees the head slot, so a full column may still take a write.
  always_comb begin
    wr_acc  = '0;
    ovf_evt = 1'b0;
    for (int c = 0; c < col; c++) begin
      wr_acc[c] = wr[c] & (~col_full[c] | rd_acc);
      if (wr[c] && col_full[c] && !rd_acc)
        ovf_evt = 1'b1;
    end
  end

  // NOTE: storage carries no reset; only pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (wr_acc[c])
        mem[c][wp[c]] <= in[psum_bw*c +: psum_bw];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all regs update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wp[c]  <= '0;
        cnt[c] <= '0;
      end
      rp <= '0;
    end else begin
      for (int c = 0; c < col; c++) begin
        if (wr_acc[c])
          wp[c] <= wp[c] + 1'b1;
        case ({wr_acc[c], rd_acc})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
      end
      if (rd_acc)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out     <= '0;
      out_vld <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      out_vld <= rd_acc;
      if (rd_acc) begin
        for (int c = 0; c < col; c++)
          out[psum_bw*c +: psum_bw] <= mem[c][rp];
      end
      if (ovf_evt)
        o_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo.sv
// Directed self-checking bench for ofifo: skew de-skew, full/overflow, full
// write+read, pointer wrap, empty reads and asynchronous reset.
module tb_ofifo;

  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int W   = COL * PW;

  logic           clk = 1'b0;
  logic           reset;
  logic [COL-1:0] wr;
  logic [W-1:0]   in;
  logic           rd;
  logic [W-1:0]   out;
  logic           out_vld;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic           o_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  ofifo #(.col(COL), .psum_bw(PW), .depth(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .out     (out),
    .out_vld (out_vld),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Row whose column c slice is {c, v[11:0]}, so column swaps are visible.
  function automatic logic [W-1:0] mk(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++)
      r[PW*c +: PW] = 16'((c << 12) | (v & 'hfff));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic write_row(input int v);
    wr = '1; in = mk(v); rd = 1'b0;
    tick();
    wr = '0;
  endtask

  task automatic read_row(input string tag, input int v);
    rd = 1'b1; wr = '0;
    tick();
    rd = 1'b0;
    check({tag, "_vld"}, W'(out_vld), W'(1));
    check(tag, out, mk(v));
  endtask

  initial begin
    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    #12;
    check("rst_out",     out, '0);
    check("rst_out_vld", W'(out_vld), W'(0));
    check("rst_ovf",     W'(o_ovf),   W'(0));
    check("rst_valid",   W'(o_valid), W'(0));
    check("rst_full",    W'(o_full),  W'(0));
    check("rst_ready",   W'(o_ready), W'(1));
    reset = 1'b0;
    @(negedge clk);
    tick();

    // Skewed fill: column c writes at cycle c.
    in = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    for (int c = 0; c < COL; c++) begin
      wr = COL'(1 << c);
      tick();
      check($sformatf("skew_valid_%0d", c), W'(o_valid), W'(c == COL-1));
    end
    wr = '0; rd = 1'b1;
    tick();
    rd = 1'b0;
    check("skew_out_vld", W'(out_vld), W'(1));
    check("skew_out", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    check("skew_valid_after", W'(o_valid), W'(0));
    tick();
    check("skew_vld_drop", W'(out_vld), W'(0));

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) write_row(i);
    check("full_full",  W'(o_full),  W'(1));
    check("full_ready", W'(o_ready), W'(0));
    check("full_ovf0",  W'(o_ovf),   W'(0));
    write_row(16'h0aa);
    check("full_ovf1",  W'(o_ovf),   W'(1));
    for (int i = 0; i < 16; i++) read_row($sformatf("full_rd_%0d", i), i);
    check("full_drained", W'(o_valid), W'(0));
    check("ovf_sticky",   W'(o_ovf),   W'(1));

    // Write and read together on a full FIFO.
    do_reset();
    for (int i = 0; i < 16; i++) write_row(i);
    wr = '1; in = mk(99); rd = 1'b1;
    tick();
    wr = '0; rd = 1'b0;
    check("wrrd_out",  out, mk(0));
    check("wrrd_full", W'(o_full), W'(1));
    check("wrrd_ovf",  W'(o_ovf),  W'(0));
    for (int i = 1; i < 16; i++) read_row($sformatf("wrrd_rd_%0d", i), i);
    read_row("wrrd_rd_99", 99);
    check("wrrd_empty", W'(o_valid), W'(0));

    // Streamed write/read pairs across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      wr = '1; in = mk(200 + i); rd = (i > 0);
      tick();
      if (i > 0) begin
        check($sformatf("wrap_vld_%0d", i), W'(out_vld), W'(1));
        check($sformatf("wrap_out_%0d", i), out, mk(200 + i - 1));
      end
    end
    read_row("wrap_last", 239);
    check("wrap_empty", W'(o_valid), W'(0));
    check("wrap_ovf",   W'(o_ovf),   W'(0));

    // Reads while empty change nothing.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd = 1'b1;
      tick();
      check($sformatf("empty_vld_%0d", i), W'(out_vld), W'(0));
      check($sformatf("empty_out_%0d", i), out, '0);
    end
    rd = 1'b0;
    write_row(16'h055);
    read_row("empty_then_rd", 16'h055);

    // Asynchronous reset with 5 rows held, out_vld and o_ovf both high.
    do_reset();
    for (int i = 0; i < 16; i++) write_row(300 + i);
    write_row(16'h0bb);
    for (int i = 0; i < 11; i++) read_row($sformatf("ar_rd_%0d", i), 300 + i);
    check("ar_pre_valid", W'(o_valid), W'(1));
    check("ar_pre_ovf",   W'(o_ovf),   W'(1));
    #1;
    reset = 1'b1;
    #1;
    check("ar_valid", W'(o_valid), W'(0));
    check("ar_vld",   W'(out_vld), W'(0));
    check("ar_ovf",   W'(o_ovf),   W'(0));
    check("ar_out",   out, '0);
    reset = 1'b0;
    tick();
    write_row(16'h077);
    write_row(16'h078);
    read_row("ar_fresh_0", 16'h077);
    read_row("ar_fresh_1", 16'h078);
    check("ar_fresh_empty", W'(o_valid), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO directly downstream of the MAC array. It captures each column's 16-bit partial sum in that column's own FIFO when the column's valid bit pulses. The array's valid bits arrive skewed across columns, one cycle apart. The block releases a full aligned row of `col` psums to the readout/SFU stage only once every column holds data, which de-skews the array output.

## Interface
- `col`, default 8: number of columns and independent column FIFOs.
- `psum_bw`, default 16: width of one partial sum.
- `depth`, default 16: entries per column FIFO; must be a power of 2, ≥ 2.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `wr`  in  `col`: per-column write strobe, driven from the array's `valid` output.
- `in`  in  `psum_bw*col`: column c data on bits [psum_bw*(c+1)-1 : psum_bw*c], driven from array `out_s`.
- `rd`  in  1: row read request.
- `out`  out  `psum_bw*col`: registered aligned row, same column packing as `in`.
- `out_vld`  out  1: one-cycle pulse marking `out` updated with a newly popped row.
- `o_valid`  out  1: every column holds ≥1 entry, so a row is readable.
- `o_full`  out  1: at least one column holds `depth` entries.
- `o_ready`  out  1: equals ~`o_full`; every column can accept a write.
- `o_ovf`  out  1: sticky flag, a write was dropped.

## Operation
- Per column c: storage array `depth` × `psum_bw`, write pointer `wp[c]`, occupancy `cnt[c]` (0..`depth`, width log2(depth)+1).
- Read pointer `rp` is shared by all columns, because reads always pop all columns together.
- Read accept: `rd_acc = rd & o_valid`.
  - On accept, `out` <= head entry of every column at `rp`, `rp` <= `rp`+1, and every `cnt[c]` decrements.
  - `rd` with `o_valid`=0 is ignored: no state change and no `out_vld`.
- Write accept, column c: `wr_acc[c] = wr[c] & (cnt[c] < depth | rd_acc)`.
  - On accept, entry `wp[c]` <= `in` slice c, `wp[c]` increments, and `cnt[c]` increments.
  - A write and a read on the same column in the same cycle leave `cnt[c]` unchanged. This holds even when the column is full, because the read frees the slot in that same edge.
  - `wr[c]` on a full column with no `rd_acc`: the write is dropped, contents and pointers are unchanged, and `o_ovf` <= 1 until reset.
- Pointers wrap modulo `depth`, with no gap or skipped entry at wrap.
- `o_valid`, `o_full`, and `o_ready` are combinational from the registered `cnt` values only, never from the current `wr` or `rd`.
- Data is delivered in arrival order per column. Row k of `out` is the k-th accepted write of each column, regardless of skew between columns.

## Timing
- Reset values: `out`=0, `out_vld`=0, `o_ovf`=0, all `cnt`=0, `wp`=0, `rp`=0. Therefore `o_valid`=0, `o_full`=0, `o_ready`=1. Storage contents are not reset.
- Reset asserted mid-operation returns to the state above immediately (async). The first edge after deassertion behaves as post-reset.
- Write-to-readable latency: a write accepted at edge N raises `o_valid` after edge N, provided the other columns are non-empty. A write to an empty column on the same edge as an `rd` cannot satisfy that `rd`.
- Read latency: `rd_acc` sampled at edge N gives `out` and `out_vld`=1 after edge N. `out_vld` drops after N+1 unless another accept occurs.
- Back-to-back reads sustain one row per cycle while `o_valid` stays 1.
- With the array's skew, column c's k-th write lands c cycles after column 0's. `o_valid` rises the cycle after column `col`-1's first write.

## Test plan
- Reset, then skewed fill: drive `wr`=1<<c at cycle c for c=0..7 with `in` slice c = 0x0100+c, and hold `rd`=0.
  - `o_valid`=0 through cycle 7 and 1 after cycle 7.
  - Then `rd`=1 for one cycle gives `out`=0x0107_0106_…_0100 and `out_vld`=1 one cycle later.
  - `o_valid` then returns to 0.
- Fill to full: write all columns 16 times with values 0..15.
  - `o_full`=1 and `o_ready`=0.
  - A 17th write gives `o_ovf`=1 and leaves contents unchanged.
  - 16 back-to-back reads return 0..15 in order, then `o_valid`=0.
- Write and read on full: with all columns full, assert `wr`=0xFF with value 99 together with `rd`.
  - The head pops, counts stay 16, and `o_ovf` stays 0.
  - Value 99 is read as the 16th row later.
- Wrap-around: 40 streamed write/read pairs with incrementing data.
  - Every output row equals its input and nothing is dropped across pointer wrap.
- Read when empty: `rd`=1 for 5 cycles after reset.
  - `out_vld` stays 0, `out` stays 0, and the pointers do not change.
  - A subsequent valid row is read correctly.
- Async reset mid-stream: assert `reset` between clock edges while `cnt`=5.
  - `o_valid`, `out_vld`, and `o_ovf` go to 0 immediately.
  - After deassertion, a fresh fill and read works from `rp`=0.
